// File: rtl/vga_mode_controller.sv
// Run-time video-mode sequencer for the VGA timing generator: swaps preset
// timing parameters at a vsync boundary and holds blanking while the new mode settles.
module vga_mode_controller #(
  parameter int DEFAULT_MODE   = 0,
  parameter int SETTLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [1:0]  mode_sel,
  input  logic        mode_req,
  output logic        mode_ack,
  output logic        busy,
  output logic [1:0]  current_mode,
  input  logic        vga_vs,
  output logic        timing_hold,
  output logic        timeout_flag,
  output logic [11:0] h_disp,
  output logic [11:0] h_fporch,
  output logic [11:0] h_sync,
  output logic [11:0] h_bporch,
  output logic [11:0] v_disp,
  output logic [11:0] v_fporch,
  output logic [11:0] v_sync,
  output logic [11:0] v_bporch
);

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, SETTLE, DONE} state_t;

  localparam logic [1:0]  DEF_MODE = 2'(DEFAULT_MODE);
  localparam logic [3:0]  SETTLE_N = 4'(SETTLE_FRAMES);
  localparam logic [20:0] TMO_LAST = 21'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [1:0]  pending;
  logic        vs_q;
  logic [20:0] tmo_cnt;
  logic [3:0]  frame_cnt;
  logic        vs_fall;

  // Packed as {h disp, fp, sync, bp, v disp, fp, sync, bp}.
  function automatic logic [95:0] mode_params(input logic [1:0] m);
    case (m)
      2'd0:    return {12'd640,  12'd16, 12'd96,  12'd48,  12'd480,  12'd10, 12'd2, 12'd33};
      2'd1:    return {12'd800,  12'd40, 12'd128, 12'd88,  12'd600,  12'd1,  12'd4, 12'd23};
      2'd2:    return {12'd1024, 12'd24, 12'd136, 12'd160, 12'd768,  12'd3,  12'd6, 12'd29};
      default: return {12'd1280, 12'd48, 12'd112, 12'd248, 12'd1024, 12'd1,  12'd3, 12'd38};
    endcase
  endfunction

  assign vs_fall = vs_q & ~vga_vs;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      pending      <= DEF_MODE;
      current_mode <= DEF_MODE;
      {h_disp, h_fporch, h_sync, h_bporch,
       v_disp, v_fporch, v_sync, v_bporch} <= mode_params(DEF_MODE);
      mode_ack     <= 1'b0;
      busy         <= 1'b0;
      timing_hold  <= 1'b0;
      timeout_flag <= 1'b0;
      vs_q         <= 1'b1;
      tmo_cnt      <= '0;
      frame_cnt    <= '0;
    end else begin
      vs_q     <= vga_vs;
      mode_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (mode_req) begin
            busy <= 1'b1;
            if (mode_sel == current_mode) begin
              mode_ack <= 1'b1;
              state    <= DONE;
            end else begin
              pending      <= mode_sel;
              timeout_flag <= 1'b0;
              tmo_cnt      <= '0;
              state        <= WAIT_EDGE;
            end
          end
        end
        WAIT_EDGE: begin
          tmo_cnt <= tmo_cnt + 21'd1;
          // A real edge wins over a simultaneous timeout, so the flag only marks forced swaps.
          if (vs_fall || (tmo_cnt == TMO_LAST)) begin
            {h_disp, h_fporch, h_sync, h_bporch,
             v_disp, v_fporch, v_sync, v_bporch} <= mode_params(pending);
            current_mode <= pending;
            timing_hold  <= 1'b1;
            frame_cnt    <= SETTLE_N;
            state        <= SETTLE;
            if (!vs_fall) timeout_flag <= 1'b1;
          end
        end
        SETTLE: begin
          if (vs_fall) begin
            frame_cnt <= frame_cnt - 4'd1;
            if (frame_cnt == 4'd1) begin
              timing_hold <= 1'b0;
              mode_ack    <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_mode_controller.sv
// Scoreboard bench for vga_mode_controller: directed mode changes, settle,
// same-mode, timeout, ignored requests and mid-sequence reset.
module tb_vga_mode_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode_sel = 2'd0;
  logic        mode_req = 1'b0;
  logic        vga_vs = 1'b1;
  logic        mode_ack, busy, timing_hold, timeout_flag;
  logic [1:0]  current_mode;
  logic [11:0] h_disp, h_fporch, h_sync, h_bporch;
  logic [11:0] v_disp, v_fporch, v_sync, v_bporch;
  logic [95:0] params;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic       tflag;
  } exp_t;
  exp_t exp_q[$];

  vga_mode_controller #(
    .DEFAULT_MODE(0), .SETTLE_FRAMES(2), .TIMEOUT_CYCLES(64)
  ) dut (
    .pixel_clk(clk), .rst_n(rst_n), .mode_sel(mode_sel), .mode_req(mode_req),
    .mode_ack(mode_ack), .busy(busy), .current_mode(current_mode), .vga_vs(vga_vs),
    .timing_hold(timing_hold), .timeout_flag(timeout_flag),
    .h_disp(h_disp), .h_fporch(h_fporch), .h_sync(h_sync), .h_bporch(h_bporch),
    .v_disp(v_disp), .v_fporch(v_fporch), .v_sync(v_sync), .v_bporch(v_bporch)
  );

  assign params = {h_disp, h_fporch, h_sync, h_bporch, v_disp, v_fporch, v_sync, v_bporch};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [95:0] table_of(input logic [1:0] m);
    case (m)
      2'd0:    return {12'd640,  12'd16, 12'd96,  12'd48,  12'd480,  12'd10, 12'd2, 12'd33};
      2'd1:    return {12'd800,  12'd40, 12'd128, 12'd88,  12'd600,  12'd1,  12'd4, 12'd23};
      2'd2:    return {12'd1024, 12'd24, 12'd136, 12'd160, 12'd768,  12'd3,  12'd6, 12'd29};
      default: return {12'd1280, 12'd48, 12'd112, 12'd248, 12'd1024, 12'd1,  12'd3, 12'd38};
    endcase
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && mode_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 96'(cyc), 96'(-1));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_cycle", 96'(cyc), 96'(e.cyc));
        chk("ack_mode", 96'(current_mode), 96'(e.mode));
        chk("ack_params", params, table_of(e.mode));
        chk("ack_hold", 96'(timing_hold), 96'(0));
        chk("ack_tflag", 96'(timeout_flag), 96'(e.tflag));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a vsync falling edge; return one cycle after it was sampled.
  task automatic fall(input bit last, input logic [1:0] m, input logic tf);
    exp_t e;
    if (last) begin
      e.cyc = cyc + 1; e.mode = m; e.tflag = tf;
      exp_q.push_back(e);
    end
    vga_vs = 1'b0;
    tick(1);
  endtask

  task automatic rise();
    tick(2);
    vga_vs = 1'b1;
    tick(6);
  endtask

  task automatic request(input logic [1:0] sel);
    mode_sel = sel;
    mode_req = 1'b1;
    tick(1);
    mode_req = 1'b0;
  endtask

  initial begin
    exp_t e;
    tick(3);
    chk("rst_params", params, table_of(2'd0));
    chk("rst_ctrl", 96'({current_mode, busy, timing_hold, mode_ack, timeout_flag}), 96'(0));
    rst_n = 1'b1;
    tick(1);
    chk("idle_busy", 96'(busy), 96'(0));

    // Mode 0 -> 2 via vsync edge; a request during settle is ignored.
    request(2'd2);
    chk("req_busy", 96'(busy), 96'(1));
    tick(40);
    chk("pre_swap", params, table_of(2'd0));
    fall(1'b0, 2'd0, 1'b0);
    chk("swap_params", params, table_of(2'd2));
    chk("swap_hold", 96'({current_mode, timing_hold, timeout_flag}), 96'({2'd2, 1'b1, 1'b0}));
    rise();
    request(2'd3);
    chk("ignored_busy", 96'(busy), 96'(1));
    tick(2);
    fall(1'b0, 2'd0, 1'b0);
    chk("settle_hold", 96'(timing_hold), 96'(1));
    rise();
    fall(1'b1, 2'd2, 1'b0);
    chk("settle_done", 96'({current_mode, timing_hold}), 96'({2'd2, 1'b0}));
    tick(1);
    chk("done_busy", 96'(busy), 96'(0));
    rise();

    // Same-mode request: ack one cycle after acceptance, nothing else moves.
    e.cyc = cyc + 1; e.mode = 2'd2; e.tflag = 1'b0;
    exp_q.push_back(e);
    request(2'd2);
    chk("same_busy", 96'({busy, timing_hold}), 96'({1'b1, 1'b0}));
    tick(1);
    chk("same_idle", 96'(busy), 96'(0));
    chk("same_params", params, table_of(2'd2));

    // Timeout: vsync held high, swap forced 64 cycles after acceptance.
    request(2'd1);
    tick(63);
    chk("pre_timeout", params, table_of(2'd2));
    chk("pre_timeout_flag", 96'(timeout_flag), 96'(0));
    tick(1);
    chk("timeout_params", params, table_of(2'd1));
    chk("timeout_flag", 96'({timeout_flag, timing_hold}), 96'({1'b1, 1'b1}));
    fall(1'b0, 2'd0, 1'b0);
    rise();
    fall(1'b1, 2'd1, 1'b1);
    chk("timeout_settled", 96'(timing_hold), 96'(0));
    rise();

    // An edge in the acceptance cycle is not counted; next request clears the flag.
    mode_sel = 2'd3;
    mode_req = 1'b1;
    vga_vs = 1'b0;
    tick(1);
    mode_req = 1'b0;
    chk("tflag_clear", 96'(timeout_flag), 96'(0));
    tick(2);
    chk("accept_edge_ignored", params, table_of(2'd1));
    vga_vs = 1'b1;
    tick(5);
    fall(1'b0, 2'd0, 1'b0);
    chk("mode3_params", params, table_of(2'd3));
    rise();
    fall(1'b0, 2'd0, 1'b0);
    rise();
    fall(1'b1, 2'd3, 1'b0);
    rise();

    // Reset during WAIT_EDGE aborts with no ack and reverts to the default mode.
    request(2'd0);
    request(2'd1);
    tick(5);
    rst_n = 1'b0;
    tick(1);
    chk("abort_params", params, table_of(2'd0));
    chk("abort_ctrl", 96'({current_mode, busy, timing_hold, mode_ack}), 96'(0));
    rst_n = 1'b1;
    fall(1'b0, 2'd0, 1'b0);
    rise();
    fall(1'b0, 2'd0, 1'b0);
    rise();
    tick(70);
    chk("abort_mode", 96'({current_mode, busy}), 96'(0));
    chk("acks_outstanding", 96'(exp_q.size()), 96'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
